// File: rtl/formula_sum_isqrt_pipe_aware_fsm_if.sv
// rtl/formula_sum_isqrt_pipe_aware_fsm_if.sv - batch, result and isqrt-unit signals of the sum-of-roots engine
interface formula_sum_isqrt_pipe_aware_fsm_if #(
  parameter int N_ARGS = 3,
  parameter int X_W    = 32,
  parameter int Y_W    = 16,
  parameter int RES_W  = 32
);
  logic                    arg_vld;
  logic                    arg_rdy;
  logic [N_ARGS*X_W-1:0]   args;
  logic                    res_vld;
  logic [RES_W-1:0]        res;
  logic                    err_unexp;
  logic                    isqrt_x_vld;
  logic [X_W-1:0]          isqrt_x;
  logic                    isqrt_y_vld;
  logic [Y_W-1:0]          isqrt_y;

  modport slave (
    input  arg_vld, args, isqrt_y_vld, isqrt_y,
    output arg_rdy, res_vld, res, err_unexp, isqrt_x_vld, isqrt_x
  );

  modport master (
    output arg_vld, args, isqrt_y_vld, isqrt_y,
    input  arg_rdy, res_vld, res, err_unexp, isqrt_x_vld, isqrt_x
  );
endinterface

// File: rtl/formula_sum_isqrt_pipe_aware_fsm.sv
// rtl/formula_sum_isqrt_pipe_aware_fsm.sv - sums isqrt of N_ARGS operands via a shared pipelined isqrt unit
module formula_sum_isqrt_pipe_aware_fsm #(
  parameter int N_ARGS    = 3,
  parameter int X_W       = 32,
  parameter int Y_W       = 16,
  parameter int RES_W     = 32,
  parameter int ISQRT_LAT = 16
) (
  input logic clk,
  input logic rst,
  formula_sum_isqrt_pipe_aware_fsm_if.slave io
);
  localparam int IDX_W = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;
  localparam int OUT_W = $clog2(ISQRT_LAT + N_ARGS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ARGS - 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [N_ARGS-1:0][X_W-1:0]  batch_q, batch_d;
  logic [OUT_W-1:0]            out_q, out_d;
  logic [RES_W-1:0]            acc_q, res_q;
  logic [IDX_W-1:0]            cnt_q;
  logic                        res_vld_q, err_q;

  logic                        arg_rdy, x_vld, y_ok;
  logic [X_W-1:0]              x;
  logic [Y_W-1:0]              y_in;
  logic [RES_W-1:0]            sum;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    batch_d = batch_q;
    arg_rdy = 1'b0;
    x_vld   = 1'b0;
    x       = batch_q[idx_q];
    unique case (state_q)
      IDLE: begin
        arg_rdy = 1'b1;
        if (io.arg_vld) begin
          // operand 0 bypasses the batch register so issue starts in the accept cycle
          x       = io.args[X_W-1:0];
          x_vld   = 1'b1;
          batch_d = io.args;
          idx_d   = IDX_W'(1);
          state_d = (N_ARGS == 1) ? IDLE : ISSUE;
        end
      end
      ISSUE: begin
        x_vld   = 1'b1;
        arg_rdy = (idx_q == LAST_IDX);
        if (idx_q != LAST_IDX) begin
          idx_d = idx_q + IDX_W'(1);
        end else if (io.arg_vld) begin
          batch_d = io.args;
          idx_d   = '0;
        end else begin
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // a zero-latency return alongside its own issue is legitimate, not unexpected
  assign y_in  = io.isqrt_y;
  assign y_ok  = io.isqrt_y_vld && ((out_q != '0) || x_vld);
  assign sum   = acc_q + RES_W'(y_in);
  assign out_d = out_q + OUT_W'(x_vld) - OUT_W'(y_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      batch_q   <= '0;
      out_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      batch_q   <= batch_d;
      out_q     <= out_d;
      res_vld_q <= 1'b0;
      if (y_ok) begin
        if (cnt_q == LAST_IDX) begin
          res_q     <= sum;
          res_vld_q <= 1'b1;
          acc_q     <= '0;
          cnt_q     <= '0;
        end else begin
          acc_q <= sum;
          cnt_q <= cnt_q + IDX_W'(1);
        end
      end
      if (io.isqrt_y_vld && !y_ok) begin
        err_q <= 1'b1;
      end
    end
  end

  assign io.arg_rdy     = arg_rdy;
  assign io.isqrt_x_vld = x_vld;
  assign io.isqrt_x     = x;
  assign io.res_vld     = res_vld_q;
  assign io.res         = res_q;
  assign io.err_unexp   = err_q;
endmodule

// File: tb/tb_formula_sum_isqrt_pipe_aware_fsm.sv
// tb/tb_formula_sum_isqrt_pipe_aware_fsm.sv - directed bench with a 4-cycle isqrt model
module tb_formula_sum_isqrt_pipe_aware_fsm;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [31:0] rq[$];
  logic [31:0] xq[$];
  int          xc[$];
  int          rc[$];

  logic [LAT-1:0] pv;
  logic [15:0]    py [LAT];
  logic           inj_vld = 1'b0;
  logic [15:0]    inj_y = '0;

  formula_sum_isqrt_pipe_aware_fsm_if #(.N_ARGS(3), .X_W(32), .Y_W(16), .RES_W(32)) bus ();

  formula_sum_isqrt_pipe_aware_fsm #(
    .N_ARGS(3), .X_W(32), .Y_W(16), .RES_W(32), .ISQRT_LAT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] isqrt_f(input logic [31:0] v);
    logic [15:0] r;
    logic [31:0] t;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      t = 32'(r | (16'd1 << i));
      if (t * t <= v) r = t[15:0];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], bus.isqrt_x_vld};
      py[0] <= isqrt_f(bus.isqrt_x);
      for (int i = 1; i < LAT; i++) py[i] <= py[i-1];
    end
  end

  assign bus.isqrt_y_vld = pv[LAT-1] | inj_vld;
  assign bus.isqrt_y     = pv[LAT-1] ? py[LAT-1] : inj_y;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.res_vld) begin
        rq.push_back(bus.res);
        rc.push_back(cyc);
      end
      if (bus.isqrt_x_vld) begin
        xq.push_back(bus.isqrt_x);
        xc.push_back(cyc);
      end
    end
  end

  task automatic clear_logs();
    rq.delete(); rc.delete(); xq.delete(); xc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [95:0] a);
    int n;
    n = 0;
    while (bus.arg_rdy !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL send_rdy_timeout: arg_rdy=%b required 1", bus.arg_rdy);
    end
    bus.args    = a;
    bus.arg_vld = 1'b1;
    @(posedge clk); #1;
    bus.arg_vld = 1'b0;
  endtask

  task automatic wait_res(input int n);
    int k;
    k = 0;
    while (rq.size() < n && k < 100) begin
      @(posedge clk); #1; k++;
    end
    checks++;
    if (rq.size() < n) begin
      errors++;
      $display("FAIL res_timeout: got %0d results required %0d", rq.size(), n);
    end
  endtask

  task automatic test_reset();
    bus.arg_vld = 1'b0;
    bus.args    = '0;
    rst = 1'b1;
    idle(3);
    checks++; if (bus.arg_rdy !== 1'b1)     begin errors++; $display("FAIL reset_arg_rdy: got %b required 1", bus.arg_rdy); end
    checks++; if (bus.res_vld !== 1'b0)     begin errors++; $display("FAIL reset_res_vld: got %b required 0", bus.res_vld); end
    checks++; if (bus.res !== 32'd0)        begin errors++; $display("FAIL reset_res: got %0d required 0", bus.res); end
    checks++; if (bus.err_unexp !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b required 0", bus.err_unexp); end
    checks++; if (bus.isqrt_x_vld !== 1'b0) begin errors++; $display("FAIL reset_x_vld: got %b required 0", bus.isqrt_x_vld); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_single();
    clear_logs();
    send({32'd16, 32'd9, 32'd4});
    wait_res(1);
    idle(5);
    checks++; if (xq.size() != 3) begin errors++; $display("FAIL single_x_count: got %0d required 3", xq.size()); end
    if (xq.size() == 3) begin
      checks++; if (xq[0] !== 32'd4)  begin errors++; $display("FAIL single_x0: got %0d required 4", xq[0]); end
      checks++; if (xq[1] !== 32'd9)  begin errors++; $display("FAIL single_x1: got %0d required 9", xq[1]); end
      checks++; if (xq[2] !== 32'd16) begin errors++; $display("FAIL single_x2: got %0d required 16", xq[2]); end
      checks++; if (xc[2] - xc[0] != 2) begin errors++; $display("FAIL single_x_gap: span %0d required 2", xc[2] - xc[0]); end
    end
    checks++; if (rq.size() != 1) begin errors++; $display("FAIL single_res_count: got %0d required 1", rq.size()); end
    if (rq.size() >= 1) begin
      checks++; if (rq[0] !== 32'd9) begin errors++; $display("FAIL single_res: got %0d required 9", rq[0]); end
      checks++; if (rc[0] - xc[0] != 7) begin errors++; $display("FAIL single_latency: got %0d required 7", rc[0] - xc[0]); end
    end
    checks++; if (bus.res !== 32'd9 || bus.res_vld !== 1'b0) begin
      errors++; $display("FAIL single_hold: res=%0d vld=%b required 9/0", bus.res, bus.res_vld);
    end
  endtask

  task automatic test_back_to_back();
    logic [95:0] b [4];
    logic [31:0] exp_r [4];
    logic        rdy;
    int          n;
    b[0] = {32'd16, 32'd9, 32'd4};    exp_r[0] = 32'd9;
    b[1] = {32'd1, 32'd4, 32'd9};     exp_r[1] = 32'd6;
    b[2] = {32'd25, 32'd36, 32'd49};  exp_r[2] = 32'd18;
    b[3] = {32'd100, 32'd0, 32'd81};  exp_r[3] = 32'd19;
    clear_logs();
    bus.arg_vld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.args = b[k];
      n = 0;
      do begin
        rdy = bus.arg_rdy;
        @(posedge clk); #1; n++;
      end while (!rdy && n < 20);
    end
    bus.arg_vld = 1'b0;
    wait_res(4);
    idle(5);
    checks++; if (xq.size() != 12) begin errors++; $display("FAIL b2b_x_count: got %0d required 12", xq.size()); end
    if (xq.size() == 12) begin
      checks++; if (xc[11] - xc[0] != 11) begin errors++; $display("FAIL b2b_x_gap: span %0d required 11", xc[11] - xc[0]); end
    end
    checks++; if (rq.size() != 4) begin errors++; $display("FAIL b2b_res_count: got %0d required 4", rq.size()); end
    for (int k = 0; k < 4 && k < rq.size(); k++) begin
      checks++;
      if (rq[k] !== exp_r[k]) begin errors++; $display("FAIL b2b_res%0d: got %0d required %0d", k, rq[k], exp_r[k]); end
    end
  endtask

  task automatic test_extremes();
    clear_logs();
    send({3{32'hFFFF_FFFF}});
    send({3{32'd0}});
    wait_res(2);
    if (rq.size() >= 2) begin
      checks++; if (rq[0] !== 32'd196605) begin errors++; $display("FAIL max_res: got %0d required 196605", rq[0]); end
      checks++; if (rq[1] !== 32'd0)      begin errors++; $display("FAIL zero_res: got %0d required 0", rq[1]); end
    end
  endtask

  task automatic test_ignore_busy();
    clear_logs();
    idle(2);
    bus.args    = {32'd16, 32'd9, 32'd4};
    bus.arg_vld = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.arg_rdy !== 1'b0) begin errors++; $display("FAIL busy_rdy: got %b required 0", bus.arg_rdy); end
    bus.args = {3{32'd100}};
    @(posedge clk); #1;
    bus.arg_vld = 1'b0;
    wait_res(1);
    idle(10);
    checks++; if (rq.size() != 1) begin errors++; $display("FAIL busy_res_count: got %0d required 1", rq.size()); end
    if (rq.size() >= 1) begin
      checks++; if (rq[0] !== 32'd9) begin errors++; $display("FAIL busy_res: got %0d required 9", rq[0]); end
    end
    checks++; if (xq.size() != 3) begin errors++; $display("FAIL busy_x_count: got %0d required 3", xq.size()); end
    if (xq.size() == 3) begin
      checks++; if (xq[2] !== 32'd16) begin errors++; $display("FAIL busy_x2: got %0d required 16", xq[2]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    send({3{32'd100}});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(15);
    checks++; if (rq.size() != 0) begin errors++; $display("FAIL rstmid_no_res: got %0d results required 0", rq.size()); end
    send({32'd1, 32'd1, 32'd1});
    wait_res(1);
    if (rq.size() >= 1) begin
      checks++; if (rq[0] !== 32'd3) begin errors++; $display("FAIL rstmid_res: got %0d required 3", rq[0]); end
    end
  endtask

  task automatic test_unexpected();
    clear_logs();
    idle(20);
    checks++; if (bus.err_unexp !== 1'b0) begin errors++; $display("FAIL unexp_pre: got %b required 0", bus.err_unexp); end
    inj_y   = 16'd7;
    inj_vld = 1'b1;
    @(posedge clk); #1;
    inj_vld = 1'b0;
    checks++; if (bus.err_unexp !== 1'b1) begin errors++; $display("FAIL unexp_set: got %b required 1", bus.err_unexp); end
    idle(5);
    checks++; if (bus.err_unexp !== 1'b1) begin errors++; $display("FAIL unexp_sticky: got %b required 1", bus.err_unexp); end
    checks++; if (rq.size() != 0) begin errors++; $display("FAIL unexp_no_res: got %0d results required 0", rq.size()); end
    send({32'd16, 32'd16, 32'd16});
    wait_res(1);
    if (rq.size() >= 1) begin
      checks++; if (rq[0] !== 32'd12) begin errors++; $display("FAIL unexp_next_res: got %0d required 12", rq[0]); end
    end
    checks++; if (bus.err_unexp !== 1'b1) begin errors++; $display("FAIL unexp_still: got %b required 1", bus.err_unexp); end
  endtask

  initial begin
    bus.arg_vld = 1'b0;
    bus.args    = '0;
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_extremes();
    test_ignore_busy();
    test_reset_mid();
    test_unexpected();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
